caliptra_sram_ldr: RTL and testbench
====================================

# caliptra_sram_ldr

Single-port synchronous SRAM model with a priority external load port and a write-data error-injection mask. Used for the instruction memory, mailbox and preload memories of the Caliptra simulation top level. The core-side port comes from the DUT; the external port lets the harness slam memory contents before or while the core runs. The mask lets benches corrupt stored words to exercise downstream ECC checking.

## Interface
- DATA_WIDTH, 32, width of one memory word in bits.
- DEPTH, 1024, number of words.
- ADDR_WIDTH, $clog2(DEPTH), word-address width.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- cs_i  input  1  core chip select.
- we_i  input  1  core write enable; qualified by cs_i.
- addr_i  input  ADDR_WIDTH  core word address.
- wdata_i  input  DATA_WIDTH  core write data.
- flip_i  input  DATA_WIDTH  XOR error-injection mask, core writes only.
- ext_we_i  input  1  external load write strobe; highest priority.
- ext_addr_i  input  ADDR_WIDTH  external load word address.
- ext_wdata_i  input  DATA_WIDTH  external load write data, stored unmodified.
- rdata_o  output  DATA_WIDTH  registered read data.
- rvalid_o  output  1  one-cycle pulse marking new rdata_o.
- collision_o  output  1  one-cycle pulse: the core request was discarded because of an external write.

## Operation
- Storage is mem[0..DEPTH-1] of DATA_WIDTH bits. Memory contents are not reset. Contents are X/undefined until written.
- Per-cycle arbitration, evaluated at each rising edge while rst_b=1, in priority order:
  - ext_we_i=1:
    - mem[ext_addr_i] <= ext_wdata_i.
    - Any core request in that cycle is dropped; no access is performed.
    - If cs_i=1, collision_o=1 in the next cycle.
  - cs_i=1, we_i=1: mem[addr_i] <= wdata_i ^ flip_i. flip_i=0 gives a clean write.
  - cs_i=1, we_i=0: rdata_o <= mem[addr_i]; rvalid_o=1 in the next cycle.
  - Otherwise idle.
- rdata_o holds its last value on write, idle and collision cycles. It changes only on a completed read.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not a power of two):
  - Writes are ignored.
  - Reads return all-zero with rvalid_o=1.
- While rst_b=0, all writes and reads are ignored.

## Timing
- Reset values: rdata_o=0, rvalid_o=0, collision_o=0. Assertion is asynchronous; deassertion takes effect at the next rising edge.
- Read latency is 1 cycle. Address in cycle N gives data and rvalid_o in cycle N+1. Back-to-back reads are allowed every cycle.
- Write latency is 1 cycle. A read of the same address in cycle N+1 returns the newly written value, including any flip_i corruption.
- rvalid_o and collision_o are single-cycle pulses. They are never both 1 in the same cycle.
- Reset asserted mid-operation: any read in flight is discarded (rvalid_o stays 0) and the outputs go to their reset values. Memory retains its contents.

## Test plan
- Reset: rst_b=0 with random inputs -> rdata_o=0, rvalid_o=0, collision_o=0. Release reset, write 0xA5A5_0001 to addr 3, read addr 3 -> rdata_o=0xA5A5_0001 with rvalid_o=1 exactly one cycle after the read.
- Back-to-back: write addr 0..7 with value addr*0x11, then 8 consecutive reads -> rvalid_o high 8 cycles, data 0x00,0x11,...,0x77 in order, 1-cycle latency.
- Error injection: write 0x0000_00FF to addr 5 with flip_i=0x0000_0001, read addr 5 -> 0x0000_00FE. An external write of 0x0000_00FF with flip_i=0xFFFF_FFFF, read back -> 0x0000_00FF.
- Collision: ext_we_i=1 (addr 2, data 0xDEAD_BEEF) while core writes 0x1234 to addr 2 -> collision_o=1 next cycle; read addr 2 -> 0xDEAD_BEEF. External write while core reads -> rvalid_o=0, collision_o=1, rdata_o unchanged.
- Hold: read addr 1 (0x55), then idle 3 cycles and do a write to addr 4 -> rdata_o stays 0x55, rvalid_o=0 throughout.
- Mid-read reset: issue a read, assert rst_b in the following cycle -> rvalid_o never pulses, rdata_o=0. After release, earlier written data is still readable.

Source files
------------

// File: rtl/caliptra_sram_ldr_if.sv
// Core and external-load signal bundle for caliptra_sram_ldr.
// The master side drives requests and the slave (the memory) returns read data and pulses.
interface caliptra_sram_ldr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    // No backpressure: a request is accepted in the cycle it is presented, unless
    // ext_we_i wins that cycle. rvalid_o (read done) and collision_o (core request
    // dropped) are one-cycle pulses answering the previous cycle's request.
    logic                  cs_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] flip_i;
    logic                  ext_we_i;
    logic [ADDR_WIDTH-1:0] ext_addr_i;
    logic [DATA_WIDTH-1:0] ext_wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
    logic                  collision_o;

    modport master (
        output cs_i, we_i, addr_i, wdata_i, flip_i,
        output ext_we_i, ext_addr_i, ext_wdata_i,
        input  rdata_o, rvalid_o, collision_o
    );

    modport slave (
        input  cs_i, we_i, addr_i, wdata_i, flip_i,
        input  ext_we_i, ext_addr_i, ext_wdata_i,
        output rdata_o, rvalid_o, collision_o
    );
endinterface

// File: rtl/caliptra_sram_ldr.sv
// Single-port SRAM model with a priority external load port and an XOR
// error-injection mask applied to core writes only.
module caliptra_sram_ldr #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_b,
    caliptra_sram_ldr_if.slave bus
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_collision;

    logic                  w_core_in_range;
    logic                  w_ext_in_range;
    logic                  w_core_wr;
    logic                  w_core_rd;
    logic                  w_collision;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // Only reachable when DEPTH is not a power of two.
    assign w_core_in_range = (32'(bus.addr_i) < 32'(DEPTH));
    assign w_ext_in_range  = (32'(bus.ext_addr_i) < 32'(DEPTH));

    assign w_core_wr   = bus.cs_i && bus.we_i && !bus.ext_we_i;
    assign w_core_rd   = bus.cs_i && !bus.we_i && !bus.ext_we_i;
    assign w_collision = bus.cs_i && bus.ext_we_i;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.addr_i;
        w_mem_wdata = bus.wdata_i ^ bus.flip_i;
        if (bus.ext_we_i) begin
            w_mem_we    = w_ext_in_range;
            w_mem_addr  = bus.ext_addr_i;
            w_mem_wdata = bus.ext_wdata_i;
        end else if (w_core_wr) begin
            w_mem_we = w_core_in_range;
        end
    end

    assign w_rd_word = w_core_in_range ? r_mem[bus.addr_i] : '0;

    // Memory shares the reset block so writes are blocked during reset, but it is never cleared.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_rvalid    <= w_core_rd;
            r_collision <= w_collision;
            if (w_core_rd) begin
                r_rdata <= w_rd_word;
            end
            if (w_mem_we) begin
                r_mem[w_mem_addr] <= w_mem_wdata;
            end
        end
    end

    assign bus.rdata_o     = r_rdata;
    assign bus.rvalid_o    = r_rvalid;
    assign bus.collision_o = r_collision;
endmodule

// File: tb/tb_caliptra_sram_ldr.sv
// Self-checking bench for caliptra_sram_ldr: reference memory model feeding an
// expected-read queue, plus a small non-power-of-two instance for range checks.
module tb_caliptra_sram_ldr;
    localparam int DW = 32;
    localparam int DEPTH = 1024;
    localparam int AW = $clog2(DEPTH);
    localparam int DEPTH2 = 12;
    localparam int AW2 = $clog2(DEPTH2);

    logic clk;
    logic rst_b;
    logic mon_en;

    int n_checks = 0;
    int n_err = 0;

    caliptra_sram_ldr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();
    caliptra_sram_ldr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH2)) bus2 ();

    caliptra_sram_ldr #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    caliptra_sram_ldr #(.DATA_WIDTH(DW), .DEPTH(DEPTH2)) dut2 (
        .clk_i (clk),
        .rst_b (rst_b),
        .bus   (bus2.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // reference model and scoreboard
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic          exp_rvalid = 1'b0;
    logic          exp_coll = 1'b0;
    logic [DW-1:0] exp_hold = '0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            exp_rvalid <= 1'b0;
            exp_coll   <= 1'b0;
            exp_q.delete();
        end else begin
            exp_rvalid <= 1'b0;
            exp_coll   <= 1'b0;
            if (bus.ext_we_i) begin
                mdl_mem[bus.ext_addr_i] <= bus.ext_wdata_i;
                exp_coll <= bus.cs_i;
            end else if (bus.cs_i && bus.we_i) begin
                mdl_mem[bus.addr_i] <= bus.wdata_i ^ bus.flip_i;
            end else if (bus.cs_i) begin
                exp_q.push_back(mdl_mem[bus.addr_i]);
                exp_rvalid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [DW-1:0] exp_d;
            if (!rst_b) exp_hold = '0;
            check("rvalid", bus.rvalid_o, exp_rvalid);
            check("collision", bus.collision_o, exp_coll);
            check("no_double_pulse", bus.rvalid_o & bus.collision_o, 1'b0);
            if (bus.rvalid_o && exp_q.size() > 0) begin
                exp_d = exp_q.pop_front();
                check("rdata", bus.rdata_o, exp_d);
                exp_hold = exp_d;
            end else begin
                check("rdata_hold", bus.rdata_o, exp_hold);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic cs, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] flip,
                         input logic ext_we, input logic [AW-1:0] ext_addr,
                         input logic [DW-1:0] ext_wdata);
        @(posedge clk);
        #1;
        bus.cs_i = cs;
        bus.we_i = we;
        bus.addr_i = addr;
        bus.wdata_i = wdata;
        bus.flip_i = flip;
        bus.ext_we_i = ext_we;
        bus.ext_addr_i = ext_addr;
        bus.ext_wdata_i = ext_wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] f);
        drive(1'b1, 1'b1, a, d, f, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b1, 1'b0, a, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        bus.cs_i = 1'b0;
        bus.we_i = 1'b0;
        bus.ext_we_i = 1'b0;
        bus.flip_i = '0;
    endtask

    task automatic op2(input logic cs, input logic we, input logic [AW2-1:0] a,
                       input logic [DW-1:0] d, output logic rv, output logic [DW-1:0] rdat);
        @(posedge clk);
        #1;
        bus2.cs_i = cs;
        bus2.we_i = we;
        bus2.addr_i = a;
        bus2.wdata_i = d;
        @(posedge clk);
        #1;
        rv = bus2.rvalid_o;
        rdat = bus2.rdata_o;
        bus2.cs_i = 1'b0;
        bus2.we_i = 1'b0;
    endtask

    initial begin
        logic          rv;
        logic [DW-1:0] rdat;
        rst_b = 1'b0;
        mon_en = 1'b0;
        bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.flip_i = '0; bus.ext_we_i = 1'b0; bus.ext_addr_i = '0; bus.ext_wdata_i = '0;
        bus2.cs_i = 1'b0; bus2.we_i = 1'b0; bus2.addr_i = '0; bus2.wdata_i = '0;
        bus2.flip_i = '0; bus2.ext_we_i = 1'b0; bus2.ext_addr_i = '0; bus2.ext_wdata_i = '0;
        @(posedge clk);
        mon_en = 1'b1;

        // random activity while held in reset
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
        release_reset();

        wr(3, 32'hA5A5_0001, '0);
        rd(3);
        idle();

        for (int a = 0; a < 8; a++) wr(AW'(a), DW'(a * 32'h11), '0);
        for (int a = 0; a < 8; a++) rd(AW'(a));
        idle();

        // error injection on core writes, none on external writes
        wr(5, 32'h0000_00FF, 32'h0000_0001);
        rd(5);
        drive(1'b0, 1'b0, '0, '0, 32'hFFFF_FFFF, 1'b1, 6, 32'h0000_00FF);
        rd(6);
        idle();

        // collisions: external beats core write, then beats core read
        drive(1'b1, 1'b1, 2, 32'h0000_1234, '0, 1'b1, 2, 32'hDEAD_BEEF);
        rd(2);
        drive(1'b1, 1'b0, 3, '0, '0, 1'b1, 7, 32'h0000_600D);
        idle();
        rd(7);

        // hold rdata across idle and write cycles
        wr(1, 32'h55, '0);
        rd(1);
        repeat (3) idle();
        wr(4, 32'h4444, '0);
        idle();
        idle();

        // reset arriving while a read is in flight
        rd(3);
        @(negedge clk);
        #1;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        rd(3);
        rd(0);
        rd(7);
        idle();

        for (int a = 8; a < 16; a++) wr(AW'(a), $urandom, '0);
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: idle();
                1: wr(AW'($urandom_range(0, 15)), $urandom,
                      ($urandom_range(0, 1) != 0) ? DW'($urandom) : '0);
                2: rd(AW'($urandom_range(0, 15)));
                default: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               AW'($urandom_range(0, 15)), $urandom, $urandom,
                               1'b1, AW'($urandom_range(0, 15)), $urandom);
            endcase
        end
        idle();
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // non-power-of-two depth: out-of-range writes ignored, reads return zero
        op2(1'b1, 1'b1, 11, 32'hCAFE_0011, rv, rdat);
        check("d2_wr_rvalid", rv, 1'b0);
        op2(1'b1, 1'b0, 11, '0, rv, rdat);
        check("d2_rd11_rvalid", rv, 1'b1);
        check("d2_rd11_data", rdat, 32'hCAFE_0011);
        op2(1'b1, 1'b1, 14, 32'h1234_5678, rv, rdat);
        op2(1'b1, 1'b0, 14, '0, rv, rdat);
        check("d2_rd14_rvalid", rv, 1'b1);
        check("d2_rd14_data", rdat, 32'h0);
        op2(1'b1, 1'b0, 11, '0, rv, rdat);
        check("d2_rd11_again", rdat, 32'hCAFE_0011);
        op2(1'b1, 1'b0, 13, '0, rv, rdat);
        check("d2_rd13_rvalid", rv, 1'b1);
        check("d2_rd13_data", rdat, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
